// File: rtl/assoc_pkg.sv
`default_nettype none
// ============================================================================
// Module : assoc_pkg
// Brief  : Command, response and FSM encodings shared by the associative store.
// Rev    : 1.0
// ============================================================================
package assoc_pkg;

    typedef enum logic [1:0] {
        SET = 2'd0,
        DEL = 2'd1,
        CLR = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        FULL     = 2'd1,
        NOTFOUND = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MATCH  = 2'd1,
        COMMIT = 2'd2,
        CLEAR  = 2'd3
    } state_e;

endpackage : assoc_pkg
`default_nettype wire

// File: rtl/assoc_match.sv
`default_nettype none
// ============================================================================
// Module : assoc_match
// Brief  : Combinational parallel key compare with lowest-free-slot search.
// Rev    : 1.0
// ============================================================================
module assoc_match
    import assoc_pkg::*;
#(
    parameter int KEY_W = 64,
    parameter int DEPTH = 8
) (
    input  logic [KEY_W-1:0]              key,
    input  logic [DEPTH-1:0][KEY_W-1:0]   keys,
    input  logic [DEPTH-1:0]              valid,
    output logic                          hit,
    output logic [$clog2(DEPTH)-1:0]      hit_idx,
    output logic [$clog2(DEPTH)-1:0]      free_idx,
    output logic                          full
);

    localparam int c_idx_w = $clog2(DEPTH);

    // Scan high to low so the lowest matching / free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        full     = &valid;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (keys[i] == key)) begin
                hit     = 1'b1;
                hit_idx = c_idx_w'(i);
            end
            if (!valid[i]) begin
                free_idx = c_idx_w'(i);
            end
        end
    end

endmodule : assoc_match
`default_nettype wire

// File: rtl/assoc_store.sv
`default_nettype none
// ============================================================================
// Module : assoc_store
// Brief  : Small key/value store with SET/DEL/CLR commands and 1-cycle lookup.
// Rev    : 1.0
// ============================================================================
module assoc_store
    import assoc_pkg::*;
#(
    parameter int               KEY_W       = 64,
    parameter int               VAL_W       = 32,
    parameter int               DEPTH       = 8,
    parameter logic [VAL_W-1:0] DEFAULT_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [1:0]                 wr_op,
    input  logic [KEY_W-1:0]           wr_key,
    input  logic [VAL_W-1:0]           wr_val,
    output logic                       wr_resp_valid,
    output logic [1:0]                 wr_resp,
    input  logic                       rd_valid,
    input  logic [KEY_W-1:0]           rd_key,
    output logic                       rd_resp_valid,
    output logic                       rd_hit,
    output logic [VAL_W-1:0]           rd_val,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                 c_idx_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = c_idx_w + 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH - 1);

    state_e                          state_q, state_d;
    op_e                             op_q, op_d;
    logic [KEY_W-1:0]                key_q, key_d;
    logic [VAL_W-1:0]                val_q, val_d;
    logic                            hit_q, hit_d;
    logic [c_idx_w-1:0]              hit_idx_q, hit_idx_d;
    logic [c_idx_w-1:0]              free_idx_q, free_idx_d;
    logic                            full_q, full_d;
    logic [c_idx_w-1:0]              clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [c_cnt_w-1:0]              count_q, count_d;
    logic [DEPTH-1:0][KEY_W-1:0]     keys_q, keys_d;
    logic [DEPTH-1:0][VAL_W-1:0]     vals_q, vals_d;
    logic                            rd_resp_valid_q, rd_resp_valid_d;
    logic                            rd_hit_q, rd_hit_d;
    logic [VAL_W-1:0]                rd_val_q, rd_val_d;

    logic                            w_accept;
    logic                            w_wr_hit, w_wr_full;
    logic [c_idx_w-1:0]              w_wr_hit_idx, w_wr_free_idx;
    logic                            w_rd_hit, w_rd_full;
    logic [c_idx_w-1:0]              w_rd_hit_idx, w_rd_free_idx;
    logic                            unused_rd;

    assoc_match #(
        .KEY_W (KEY_W),
        .DEPTH (DEPTH)
    ) u_wr_match (
        .key      (key_q),
        .keys     (keys_q),
        .valid    (valid_q),
        .hit      (w_wr_hit),
        .hit_idx  (w_wr_hit_idx),
        .free_idx (w_wr_free_idx),
        .full     (w_wr_full)
    );

    assoc_match #(
        .KEY_W (KEY_W),
        .DEPTH (DEPTH)
    ) u_rd_match (
        .key      (rd_key),
        .keys     (keys_q),
        .valid    (valid_q),
        .hit      (w_rd_hit),
        .hit_idx  (w_rd_hit_idx),
        .free_idx (w_rd_free_idx),
        .full     (w_rd_full)
    );

    assign unused_rd = ^{w_rd_free_idx, w_rd_full};

    assign wr_ready = (state_q == IDLE);
    assign w_accept = wr_valid && wr_ready;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        key_d         = key_q;
        val_d         = val_q;
        hit_d         = hit_q;
        hit_idx_d     = hit_idx_q;
        free_idx_d    = free_idx_q;
        full_d        = full_q;
        clr_idx_d     = clr_idx_q;
        valid_d       = valid_q;
        count_d       = count_q;
        keys_d        = keys_q;
        vals_d        = vals_q;
        wr_resp_valid = 1'b0;
        wr_resp       = OK;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    op_d      = op_e'(wr_op);
                    key_d     = wr_key;
                    val_d     = wr_val;
                    clr_idx_d = '0;
                    if (op_e'(wr_op) == CLR) begin
                        // Occupancy already reads as the post-sweep value so it is 0 at completion.
                        count_d = '0;
                        state_d = CLEAR;
                    end else begin
                        state_d = MATCH;
                    end
                end
            end
            MATCH: begin
                hit_d      = w_wr_hit;
                hit_idx_d  = w_wr_hit_idx;
                free_idx_d = w_wr_free_idx;
                full_d     = w_wr_full;
                state_d    = COMMIT;
            end
            COMMIT: begin
                wr_resp_valid = 1'b1;
                state_d       = IDLE;
                case (op_q)
                    SET: begin
                        if (hit_q) begin
                            vals_d[hit_idx_q] = val_q;
                        end else if (!full_q) begin
                            keys_d[free_idx_q]  = key_q;
                            vals_d[free_idx_q]  = val_q;
                            valid_d[free_idx_q] = 1'b1;
                            count_d             = count_q + 1'b1;
                        end else begin
                            wr_resp = FULL;
                        end
                    end
                    DEL: begin
                        if (hit_q) begin
                            valid_d[hit_idx_q] = 1'b0;
                            count_d            = count_q - 1'b1;
                        end else begin
                            wr_resp = NOTFOUND;
                        end
                    end
                    // The reserved encoding completes without touching storage.
                    default: wr_resp = NOTFOUND;
                endcase
            end
            CLEAR: begin
                valid_d[clr_idx_q] = 1'b0;
                clr_idx_d          = clr_idx_q + 1'b1;
                if (clr_idx_q == c_last_idx) begin
                    wr_resp_valid = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lookups sample storage before any same-edge write or clear step lands.
    always_comb begin
        rd_resp_valid_d = rd_valid;
        rd_hit_d        = rd_valid && w_rd_hit;
        rd_val_d        = (rd_valid && w_rd_hit) ? vals_q[w_rd_hit_idx] : DEFAULT_VAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            hit_q           <= 1'b0;
            hit_idx_q       <= '0;
            free_idx_q      <= '0;
            full_q          <= 1'b0;
            clr_idx_q       <= '0;
            valid_q         <= '0;
            count_q         <= '0;
            rd_resp_valid_q <= 1'b0;
            rd_hit_q        <= 1'b0;
            rd_val_q        <= DEFAULT_VAL;
        end else begin
            state_q         <= state_d;
            hit_q           <= hit_d;
            hit_idx_q       <= hit_idx_d;
            free_idx_q      <= free_idx_d;
            full_q          <= full_d;
            clr_idx_q       <= clr_idx_d;
            valid_q         <= valid_d;
            count_q         <= count_d;
            rd_resp_valid_q <= rd_resp_valid_d;
            rd_hit_q        <= rd_hit_d;
            rd_val_q        <= rd_val_d;
        end
    end

    // Operand and payload storage is qualified by the valid bits and carries no reset.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        key_q  <= key_d;
        val_q  <= val_d;
        keys_q <= keys_d;
        vals_q <= vals_d;
    end

    assign rd_resp_valid = rd_resp_valid_q;
    assign rd_hit        = rd_hit_q;
    assign rd_val        = rd_val_q;
    assign count         = count_q;

endmodule : assoc_store
`default_nettype wire

// File: tb/tb_assoc_store.sv
`default_nettype none
// ============================================================================
// Module : tb_assoc_store
// Brief  : Scoreboard bench for assoc_store using directed command sequences.
// Rev    : 1.0
// ============================================================================
module tb_assoc_store;
    import assoc_pkg::*;

    localparam logic [63:0] K_KAMAL = 64'h6B616D616C;
    localparam logic [63:0] K_RAM   = 64'h72616D;
    localparam logic [63:0] K_SITA  = 64'h73697461;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_op = 2'd0;
    logic [63:0] wr_key = '0;
    logic [31:0] wr_val = '0;
    logic        wr_resp_valid;
    logic [1:0]  wr_resp;
    logic        rd_valid = 1'b0;
    logic [63:0] rd_key = '0;
    logic        rd_resp_valid;
    logic        rd_hit;
    logic [31:0] rd_val;
    logic [3:0]  count;

    typedef struct {
        logic [1:0] resp;
        int         due;
        bit         chk_cnt;
        logic [3:0] cnt;
    } wr_exp_t;

    typedef struct {
        logic        hit;
        logic [31:0] val;
        int          due;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    wr_exp_t we;
    rd_exp_t re;
    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;

    assoc_store #(
        .KEY_W       (64),
        .VAL_W       (32),
        .DEPTH       (8),
        .DEFAULT_VAL (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_op         (wr_op),
        .wr_key        (wr_key),
        .wr_val        (wr_val),
        .wr_resp_valid (wr_resp_valid),
        .wr_resp       (wr_resp),
        .rd_valid      (rd_valid),
        .rd_key        (rd_key),
        .rd_resp_valid (rd_resp_valid),
        .rd_hit        (rd_hit),
        .rd_val        (rd_val),
        .count         (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_resp_valid) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_resp_unexpected: got resp=%0d at cycle %0d, none expected", wr_resp, cyc);
                end else begin
                    we = wr_q.pop_front();
                    if (wr_resp !== we.resp || cyc != we.due || (we.chk_cnt && count !== we.cnt)) begin
                        errors++;
                        $display("FAIL wr_resp: got resp=%0d cyc=%0d count=%0d, expected resp=%0d cyc=%0d count=%0d",
                                 wr_resp, cyc, count, we.resp, we.due, we.cnt);
                    end
                end
            end
            if (rd_resp_valid) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_resp_unexpected: got hit=%0d val=0x%0h at cycle %0d", rd_hit, rd_val, cyc);
                end else begin
                    re = rd_q.pop_front();
                    if (rd_hit !== re.hit || rd_val !== re.val || cyc != re.due) begin
                        errors++;
                        $display("FAIL rd_resp: got hit=%0d val=0x%0h cyc=%0d, expected hit=%0d val=0x%0h cyc=%0d",
                                 rd_hit, rd_val, cyc, re.hit, re.val, re.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [63:0] key, input logic [31:0] val,
                             input logic [1:0] resp, input bit chk_cnt, input logic [3:0] cnt);
        int n;
        wr_exp_t e;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL wr_ready_timeout: wr_ready=%0d after %0d cycles, expected 1", wr_ready, n);
        end
        wr_valid = 1'b1;
        wr_op    = op;
        wr_key   = key;
        wr_val   = val;
        e.resp    = resp;
        e.due     = cyc + ((op == CLR) ? 8 : 2);
        e.chk_cnt = chk_cnt;
        e.cnt     = cnt;
        wr_q.push_back(e);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((wr_q.size() != 0 || !wr_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (wr_q.size() != 0 || !wr_ready) begin
            checks++;
            errors++;
            $display("FAIL wr_resp_timeout: %0d responses still pending, expected 0", wr_q.size());
            wr_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [63:0] key, input logic [31:0] val,
                          input logic [1:0] resp);
        issue_cmd(op, key, val, resp, 1'b0, 4'd0);
        wait_idle();
    endtask

    task automatic do_lookup(input logic [63:0] key, input logic hit, input logic [31:0] val);
        rd_exp_t e;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_key   = key;
        e.hit = hit;
        e.val = val;
        e.due = cyc + 1;
        rd_q.push_back(e);
        @(negedge clk);
        rd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int busy;
        int n;

        repeat (2) @(negedge clk);
        chk("reset_wr_ready", 64'(wr_ready), 64'd1);
        chk("reset_wr_resp_valid", 64'(wr_resp_valid), 64'd0);
        chk("reset_wr_resp", 64'(wr_resp), 64'd0);
        chk("reset_rd_resp_valid", 64'(rd_resp_valid), 64'd0);
        chk("reset_rd_hit", 64'(rd_hit), 64'd0);
        chk("reset_rd_val", 64'(rd_val), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        rst_n = 1'b1;

        do_lookup(K_KAMAL, 1'b0, 32'h0);

        do_cmd(SET, K_RAM, 32'h28, OK);
        do_cmd(SET, K_SITA, 32'h23, OK);
        chk("count_after_two_sets", 64'(count), 64'd2);
        do_lookup(K_RAM, 1'b1, 32'h28);
        do_lookup(K_SITA, 1'b1, 32'h23);

        do_cmd(SET, K_RAM, 32'h29, OK);
        chk("count_after_overwrite", 64'(count), 64'd2);
        do_lookup(K_RAM, 1'b1, 32'h29);

        for (int i = 3; i <= 8; i++) begin
            do_cmd(SET, 64'h6B657900 | 64'(i), 32'h100 + 32'(i), OK);
        end
        chk("count_full", 64'(count), 64'd8);
        do_cmd(SET, K_KAMAL, 32'h99, FULL);
        chk("count_after_full_set", 64'(count), 64'd8);
        do_lookup(K_KAMAL, 1'b0, 32'h0);
        do_lookup(64'h6B657905, 1'b1, 32'h105);

        do_cmd(DEL, K_SITA, 32'h0, OK);
        chk("count_after_del", 64'(count), 64'd7);
        do_cmd(DEL, K_SITA, 32'h0, NOTFOUND);
        chk("count_after_del_miss", 64'(count), 64'd7);
        do_lookup(K_SITA, 1'b0, 32'h0);

        // Lookup lands in the COMMIT cycle of the overwrite, so it sees 0x29.
        issue_cmd(SET, K_RAM, 32'h30, OK, 1'b0, 4'd0);
        do_lookup(K_RAM, 1'b1, 32'h29);
        wait_idle();
        do_lookup(K_RAM, 1'b1, 32'h30);

        do_cmd(SET, K_SITA, 32'h55, OK);
        chk("count_refill", 64'(count), 64'd8);
        do_lookup(K_SITA, 1'b1, 32'h55);

        issue_cmd(CLR, 64'h0, 32'h0, OK, 1'b1, 4'd0);
        busy = 0;
        n = 0;
        while (!wr_ready && n < 40) begin
            busy++;
            @(negedge clk);
            n++;
        end
        chk("clr_busy_cycles", 64'(busy), 64'd8);
        wait_idle();
        chk("count_after_clr", 64'(count), 64'd0);
        do_lookup(K_RAM, 1'b0, 32'h0);
        do_lookup(64'h6B657908, 1'b0, 32'h0);

        do_cmd(SET, K_RAM, 32'h11, OK);
        do_cmd(SET, K_SITA, 32'h22, OK);
        chk("count_before_abort", 64'(count), 64'd2);
        do_lookup(K_SITA, 1'b1, 32'h22);

        issue_cmd(CLR, 64'h0, 32'h0, OK, 1'b1, 4'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        wr_q.delete();
        #1;
        chk("abort_wr_ready", 64'(wr_ready), 64'd1);
        chk("abort_count", 64'(count), 64'd0);
        chk("abort_wr_resp_valid", 64'(wr_resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_lookup(K_RAM, 1'b0, 32'h0);
        do_lookup(K_SITA, 1'b0, 32'h0);
        chk("count_after_abort", 64'(count), 64'd0);
        @(negedge clk);
        if (rd_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rd_resp_missing: %0d lookups unanswered, expected 0", rd_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_assoc_store
`default_nettype wire
